// File: rtl/croc_pkg.sv
// Shared croc top-level types and defaults: the reset/boot sequencer state
// encoding and the parameter defaults used by its instances.
package croc_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } rst_seq_state_e;

    localparam int unsigned RstSeqNumDomains   = 2;
    localparam int unsigned RstSeqSyncStages   = 2;
    localparam int unsigned RstSeqReleaseDelay = 16;
    localparam int unsigned RstSeqSwRstHold    = 8;

    function automatic int unsigned rst_seq_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/croc_rst_seq_sync.sv
// Plain flop-chain synchroniser for the pad-level fetch enable; the chain
// clears synchronously so it shares the reset style of the sequencer.
module croc_rst_seq_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[Stages-2:0], d};
        end
    end

    assign q = chain[Stages-1];

endmodule

// File: rtl/croc_rst_seq.sv
// Reset/boot sequencer: staggered release of NumDomains reset domains,
// per-domain software re-reset with acknowledge, and gated fetch enable.
module croc_rst_seq
    import croc_pkg::*;
#(
    parameter int unsigned NumDomains   = RstSeqNumDomains,
    parameter int unsigned SyncStages   = RstSeqSyncStages,
    parameter int unsigned ReleaseDelay = RstSeqReleaseDelay,
    parameter int unsigned SwRstHold    = RstSeqSwRstHold
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  testmode_i,
    input  logic                  fetch_en_i,
    input  logic [NumDomains-1:0] sw_rst_req_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  fetch_en_o,
    output logic                  seq_done_o,
    output logic [NumDomains-1:0] sw_rst_ack_o
);

    localparam int unsigned CntW = $clog2(rst_seq_max(ReleaseDelay, SwRstHold) + 1);
    localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CntW-1:0] RelLast  = CntW'(ReleaseDelay - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(SwRstHold - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

    if (NumDomains < 1 || NumDomains > 8) begin : g_bad_num_domains
        $error("croc_rst_seq: NumDomains must be in 1..8");
    end
    if (SyncStages < 2) begin : g_bad_sync_stages
        $error("croc_rst_seq: SyncStages must be >= 2");
    end
    if (ReleaseDelay < 1) begin : g_bad_release_delay
        $error("croc_rst_seq: ReleaseDelay must be >= 1");
    end
    if (SwRstHold < 1) begin : g_bad_sw_rst_hold
        $error("croc_rst_seq: SwRstHold must be >= 1");
    end

    rst_seq_state_e        state;
    logic [CntW-1:0]       cnt;
    logic [IdxW-1:0]       idx;
    logic [NumDomains-1:0] req_q;
    logic [NumDomains-1:0] pending;
    logic [NumDomains-1:0] rst_q;
    logic [NumDomains-1:0] ack_q;
    logic                  done_q;
    logic                  sync_q;

    logic [NumDomains-1:0] rise;
    logic [NumDomains-1:0] clr_mask;
    logic [IdxW-1:0]       first_pending;
    logic                  take;

    croc_rst_seq_sync #(
        .Stages(SyncStages)
    ) u_sync (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .d    (fetch_en_i),
        .q    (sync_q)
    );

    // Lowest-index pending domain wins arbitration.
    always_comb begin
        first_pending = '0;
        for (int k = NumDomains - 1; k >= 0; k--) begin
            if (pending[k]) begin
                first_pending = IdxW'(k);
            end
        end
    end

    assign take = (state == RUN) && (|pending);
    assign rise = (state != INIT) ? (sw_rst_req_i & ~req_q) : '0;

    always_comb begin
        clr_mask = '0;
        if (take) begin
            clr_mask[first_pending] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= INIT;
            cnt     <= '0;
            idx     <= '0;
            req_q   <= '0;
            pending <= '0;
            rst_q   <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            req_q   <= sw_rst_req_i;
            ack_q   <= '0;
            // A fresh edge on the domain being taken re-arms it for later.
            pending <= (pending & ~clr_mask) | rise;
            case (state)
                INIT: begin
                    if (cnt == RelLast) begin
                        cnt        <= '0;
                        rst_q[idx] <= 1'b1;
                        if (idx == IdxLast) begin
                            state  <= RUN;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + IdxW'(1);
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                RUN: begin
                    if (take) begin
                        idx                  <= first_pending;
                        cnt                  <= '0;
                        rst_q[first_pending] <= 1'b0;
                        state                <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == HoldLast) begin
                        rst_q[idx] <= 1'b1;
                        ack_q[idx] <= 1'b1;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign domain_rst_no = testmode_i ? {NumDomains{rst_ni}} : rst_q;
    assign seq_done_o    = done_q;
    assign sw_rst_ack_o  = ack_q;
    assign fetch_en_o    = sync_q & done_q & domain_rst_no[0];

endmodule

// File: tb/tb_croc_rst_seq.sv
// Bench for croc_rst_seq: directed boot/re-reset sequence then random traffic,
// compared cycle by cycle against a time-window reference model.
module tb_croc_rst_seq;

    localparam int N  = 3;
    localparam int RD = 4;
    localparam int SH = 3;
    localparam int SS = 2;
    localparam int W  = 2 * N + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         testmode = 1'b0;
    logic         fetch_en = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] dom_rst_n;
    logic [N-1:0] ack;
    logic         fetch_o;
    logic         done;

    always #5 clk = ~clk;

    croc_rst_seq #(
        .NumDomains  (N),
        .SyncStages  (SS),
        .ReleaseDelay(RD),
        .SwRstHold   (SH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .testmode_i   (testmode),
        .fetch_en_i   (fetch_en),
        .sw_rst_req_i (req),
        .domain_rst_no(dom_rst_n),
        .fetch_en_o   (fetch_o),
        .seq_done_o   (done),
        .sw_rst_ack_o (ack)
    );

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: m_cyc counts edges since reset release; a software
    // reset served at cycle s holds its domain low over s+1..s+SH and acks at s+SH+1.
    bit m_valid = 1'b0;
    int m_cyc = 0;
    bit m_pend[N];
    bit m_req_prev[N];
    int m_hold_dom = -1;
    int m_hold_start = -100;
    int m_ready = N * RD;
    bit m_fe_hist[$];

    function automatic logic [W-1:0] model_out(input logic rst_in, input logic tm);
        logic [N-1:0] d;
        logic [N-1:0] a;
        logic sd;
        logic sy;
        logic fe;
        for (int k = 0; k < N; k++) begin
            d[k] = (m_cyc >= (k + 1) * RD) &&
                   !(k == m_hold_dom && m_cyc > m_hold_start && m_cyc <= m_hold_start + SH);
            a[k] = (k == m_hold_dom) && (m_cyc == m_hold_start + SH + 1);
        end
        if (tm) d = {N{rst_in}};
        sd = (m_cyc >= N * RD);
        sy = (m_fe_hist.size() >= SS) ? m_fe_hist[m_fe_hist.size() - SS] : 1'b0;
        fe = sy & sd & d[0];
        return {d, fe, sd, a};
    endfunction

    task automatic model_step(input logic rst_in, input logic fe_in, input logic [N-1:0] rq);
        int sel;
        if (!rst_in) begin
            m_valid      = 1'b1;
            m_cyc        = 0;
            m_hold_dom   = -1;
            m_hold_start = -100;
            m_ready      = N * RD;
            for (int k = 0; k < N; k++) begin
                m_pend[k]     = 1'b0;
                m_req_prev[k] = 1'b0;
            end
            m_fe_hist.delete();
        end else if (m_valid) begin
            sel = -1;
            for (int k = 0; k < N; k++) begin
                if (m_pend[k] && sel < 0) sel = k;
            end
            if (m_cyc >= m_ready && sel >= 0) begin
                m_pend[sel]  = 1'b0;
                m_hold_dom   = sel;
                m_hold_start = m_cyc;
                m_ready      = m_cyc + SH + 1;
            end
            if (m_cyc >= N * RD) begin
                for (int k = 0; k < N; k++) begin
                    if (rq[k] && !m_req_prev[k]) m_pend[k] = 1'b1;
                end
            end
            for (int k = 0; k < N; k++) m_req_prev[k] = rq[k];
            m_fe_hist.push_back(fe_in);
            if (m_fe_hist.size() > SS) void'(m_fe_hist.pop_front());
            m_cyc++;
        end
    endtask

    // One cycle of stimulus: inputs for the coming edge plus the expected outputs.
    task automatic step(input logic r, input logic tm, input logic fe, input logic [N-1:0] rq);
        @(negedge clk);
        rst_n    = r;
        testmode = tm;
        fetch_en = fe;
        req      = rq;
        if (m_valid) exp_q.push_back(model_out(r, tm));
        model_step(r, fe, rq);
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] got;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {dom_rst_n, fetch_o, done, ack};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t {rst_no,fetch_en,seq_done,ack} got=%b required=%b",
                             $time, got, e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] rq;
        logic         fe;
        logic         r;
        logic         tm;

        repeat (3) step(1'b0, 1'b0, 1'b0, '0);

        // Boot, fetch enable, single and simultaneous software resets, reset mid-HOLD.
        for (int c = 0; c < 43; c++) begin
            if (c >= 20 && c < 23)  rq = 3'b010;
            else if (c >= 40)       rq = 3'b101;
            else                    rq = 3'b000;
            step(1'b1, 1'b0, (c >= 2 && c < 30), rq);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'b101);
        for (int c = 0; c < 24; c++) step(1'b1, 1'b0, 1'b1, 3'b000);

        // DFT bypass during INIT.
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        repeat (4) step(1'b1, 1'b1, 1'b1, '0);
        repeat (2) step(1'b0, 1'b1, 1'b1, '0);
        repeat (3) step(1'b1, 1'b1, 1'b1, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);

        // Random traffic with occasional resets and test-mode pulses.
        rq = '0;
        fe = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            r  = ($urandom_range(0, 249) != 0);
            tm = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 39) == 0) fe = ~fe;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0) rq[k] = ~rq[k];
            end
            step(r, tm, fe, rq);
        end

        @(negedge clk);
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
